// File: rtl/pill_feeder_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pill_feeder_if : control and status bundle between the pill feeder and the
//                  downstream bottle counter.  Rev 1.0
// ----------------------------------------------------------------------------
interface pill_feeder_if #(
   parameter int HOPPER_CAP = 200,
   parameter int LEVEL_W    = $clog2(HOPPER_CAP + 1)
);
   logic               run_en;
   logic               emergency_stop;
   logic               hopper_stop;
   logic               hopper_add;
   logic               conveyor_stop;
   logic               bottle_done;
   logic               pill_pulse;
   logic [2:0]         feeder_state;
   logic [LEVEL_W-1:0] hopper_level;
   logic               hopper_low;
   logic               hopper_empty;
   logic               alarm;

   modport master (
      output run_en, emergency_stop, hopper_stop, hopper_add, conveyor_stop, bottle_done,
      input  pill_pulse, feeder_state, hopper_level, hopper_low, hopper_empty, alarm
   );

   modport slave (
      input  run_en, emergency_stop, hopper_stop, hopper_add, conveyor_stop, bottle_done,
      output pill_pulse, feeder_state, hopper_level, hopper_low, hopper_empty, alarm
   );
endinterface
`default_nettype wire

// File: rtl/pill_feeder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pill_feeder : hopper and vibratory feeder model, one pill pulse every
//               PILL_PERIOD cycles. Optional macro: PILL_FEEDER_HOLD_WDOG_EN.
// Rev 1.0
// ----------------------------------------------------------------------------
module pill_feeder #(
   parameter int PILL_PERIOD  = 250,
   parameter int HOPPER_CAP   = 200,
   parameter int HOPPER_LOW   = 20,
   parameter int REFILL_STEP  = 50,
   parameter int SWAP_CYCLES  = 500,
   parameter int HOLD_TIMEOUT = 5000
) (
   input  logic         clk_1khz,
   input  logic         clr,
   pill_feeder_if.slave bus
);
   localparam int LEVEL_W = $clog2(HOPPER_CAP + 1);
   localparam int PER_W   = $clog2(PILL_PERIOD);
   localparam int SWAP_W  = $clog2(SWAP_CYCLES + 1);
   localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(PILL_PERIOD - 1);
   localparam logic [SWAP_W-1:0] SWAP_LAST = SWAP_W'(SWAP_CYCLES - 1);

   if (PILL_PERIOD < 2 || SWAP_CYCLES < 1 || HOLD_TIMEOUT < 1) begin : g_param_check
      $error("pill_feeder: parameter out of range");
   end

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FEED  = 3'd1,
      SWAP  = 3'd2,
      HOLD  = 3'd3,
      ESTOP = 3'd4
`ifdef PILL_FEEDER_HOLD_WDOG_EN
      , FAULT = 3'd5
`endif
   } state_t;

   state_t              state;
   state_t              state_next;
   logic [PER_W-1:0]    period_cnt;
   logic [PER_W-1:0]    period_next;
   logic [SWAP_W-1:0]   swap_cnt;
   logic [LEVEL_W-1:0]  level;
   logic [LEVEL_W-1:0]  level_next;
   logic                add_q;
   logic                pill_q;
   logic                alarm_q;
   logic                pill_tick;
   logic                alarm_next;
   logic                refill;
   logic                stop_any;
   logic                empty;
   int                  level_sum;

   assign refill   = bus.hopper_add & ~add_q;
   assign stop_any = bus.hopper_stop | bus.conveyor_stop;
   assign empty    = (level == '0);

`ifdef PILL_FEEDER_HOLD_WDOG_EN
   localparam int HOLD_W = $clog2(HOLD_TIMEOUT + 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TIMEOUT - 1);
   logic [HOLD_W-1:0] hold_cnt;
   logic              hold_expired;

   always_ff @(posedge clk_1khz) begin
      if (clr) begin
         hold_cnt <= '0;
      end else if (state == HOLD && state_next == HOLD) begin
         hold_cnt <= hold_cnt + HOLD_W'(1);
      end else begin
         hold_cnt <= '0;
      end
   end

   assign hold_expired = (hold_cnt == HOLD_LAST);
`endif

   always_ff @(posedge clk_1khz) begin
      if (clr) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      pill_tick  = 1'b0;
      if (bus.emergency_stop) begin
         state_next = ESTOP;
      end else if (state == ESTOP) begin
         if (!bus.run_en) state_next = IDLE;
      end
`ifdef PILL_FEEDER_HOLD_WDOG_EN
      else if (state == FAULT) begin
         if (!bus.run_en) state_next = IDLE;
      end
`endif
      else if (!bus.run_en) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE: state_next = (stop_any || empty) ? HOLD : FEED;
            FEED: begin
               // bottle change beats a coincident pill tick
               if (bus.bottle_done)           state_next = SWAP;
               else if (stop_any || empty)    state_next = HOLD;
               else if (period_cnt == PER_LAST) pill_tick = 1'b1;
            end
            SWAP: begin
               if (!bus.conveyor_stop && swap_cnt == SWAP_LAST) state_next = FEED;
            end
            HOLD: begin
`ifdef PILL_FEEDER_HOLD_WDOG_EN
               if (hold_expired) state_next = FAULT;
               else
`endif
               if (!stop_any && !empty) state_next = FEED;
            end
            default: state_next = IDLE;
         endcase
      end
   end

   always_comb begin
      // FEED<->HOLD keeps the pill phase; every other path restarts it
      if (pill_tick) begin
         period_next = '0;
      end else if (state == FEED && state_next == FEED) begin
         period_next = period_cnt + PER_W'(1);
      end else if ((state == FEED || state == HOLD) &&
                   (state_next == FEED || state_next == HOLD)) begin
         period_next = period_cnt;
      end else begin
         period_next = '0;
      end

      level_sum  = int'(level) + (refill ? REFILL_STEP : 0) - (pill_tick ? 1 : 0);
      level_next = (level_sum > HOPPER_CAP) ? LEVEL_W'(HOPPER_CAP) : LEVEL_W'(level_sum);

      alarm_next = (state_next == ESTOP) || (state_next == HOLD && level_next == '0);
`ifdef PILL_FEEDER_HOLD_WDOG_EN
      if (state_next == FAULT) alarm_next = 1'b1;
`endif
   end

   always_ff @(posedge clk_1khz) begin
      if (clr) begin
         period_cnt <= '0;
         swap_cnt   <= '0;
         level      <= LEVEL_W'(HOPPER_CAP);
         add_q      <= 1'b0;
         pill_q     <= 1'b0;
         alarm_q    <= 1'b0;
      end else begin
         period_cnt <= period_next;
         level      <= level_next;
         add_q      <= bus.hopper_add;
         pill_q     <= pill_tick;
         alarm_q    <= alarm_next;
         if (state == SWAP && state_next == SWAP) begin
            if (!bus.conveyor_stop) swap_cnt <= swap_cnt + SWAP_W'(1);
         end else begin
            swap_cnt <= '0;
         end
      end
   end

   assign bus.pill_pulse   = pill_q;
   assign bus.feeder_state = state;
   assign bus.hopper_level = level;
   assign bus.hopper_low   = (int'(level) <= HOPPER_LOW);
   assign bus.hopper_empty = empty;
   assign bus.alarm        = alarm_q;

endmodule
`default_nettype wire
